// File: rtl/traffic_pkg.sv
// Shared definitions for the two-street traffic controller: phase encodings,
// configuration register addresses, default timings and the lamp decode.
package traffic_pkg;

   typedef enum logic [2:0] {
      A_GREEN    = 3'd0,
      A_YELLOW   = 3'd1,
      ALL_RED_AB = 3'd2,
      B_GREEN    = 3'd3,
      B_YELLOW   = 3'd4,
      ALL_RED_BA = 3'd5,
      PED_WALK   = 3'd6
   } phase_e;

   localparam logic [1:0] CFG_GREEN_MIN = 2'd0;
   localparam logic [1:0] CFG_YELLOW    = 2'd1;
   localparam logic [1:0] CFG_ALL_RED   = 2'd2;
   localparam logic [1:0] CFG_WALK      = 2'd3;

   localparam int DEF_GREEN_MIN = 5;
   localparam int DEF_YELLOW    = 2;
   localparam int DEF_ALL_RED   = 1;
   localparam int DEF_WALK      = 4;

   typedef struct packed {
      logic ra;
      logic ya;
      logic ga;
      logic rb;
      logic yb;
      logic gb;
      logic walk;
   } lamps_t;

   // A programmed duration of zero still occupies one cycle.
   function automatic logic [7:0] clampDuration(input logic [7:0] value);
      return (value == 8'd0) ? 8'd1 : value;
   endfunction

   function automatic lamps_t lampDecode(input phase_e phase);
      lamps_t lamps;
      lamps = '{ra: 1'b1, ya: 1'b0, ga: 1'b0, rb: 1'b1, yb: 1'b0, gb: 1'b0, walk: 1'b0};
      case (phase)
         A_GREEN:  begin lamps.ra = 1'b0; lamps.ga = 1'b1; end
         A_YELLOW: begin lamps.ra = 1'b0; lamps.ya = 1'b1; end
         B_GREEN:  begin lamps.rb = 1'b0; lamps.gb = 1'b1; end
         B_YELLOW: begin lamps.rb = 1'b0; lamps.yb = 1'b1; end
         PED_WALK: lamps.walk = 1'b1;
         default:  ;
      endcase
      return lamps;
   endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable 8-bit down-counter timing each phase; it parks at 1 so a
// phase that is allowed to hold keeps reporting expiry.
module phase_timer (
   input  logic       clk,
   input  logic       load_i,
   input  logic [7:0] loadValue_i,
   output logic [7:0] value_o,
   output logic       expired_o
);

   logic [7:0] count_q;

   always_ff @(posedge clk) begin
      if (load_i) begin
         count_q <= loadValue_i;
      end else if (count_q > 8'd1) begin
         count_q <= count_q - 8'd1;
      end
   end

   assign value_o   = count_q;
   assign expired_o = (count_q <= 8'd1);

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Two-street traffic light controller with pedestrian walk phase and
// runtime-programmable phase durations; street A is the rest direction.
module traffic_phase_scheduler #(
   parameter int DEF_GREEN_MIN = traffic_pkg::DEF_GREEN_MIN,
   parameter int DEF_YELLOW    = traffic_pkg::DEF_YELLOW,
   parameter int DEF_ALL_RED   = traffic_pkg::DEF_ALL_RED,
   parameter int DEF_WALK      = traffic_pkg::DEF_WALK
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       Sa,
   input  logic       Sb,
   input  logic       ped_req,
   input  logic       cfg_we,
   input  logic [1:0] cfg_addr,
   input  logic [7:0] cfg_data,
   output logic       Ra,
   output logic       Ya,
   output logic       Ga,
   output logic       Rb,
   output logic       Yb,
   output logic       Gb,
   output logic       walk,
   output logic       ped_pending,
   output logic [2:0] phase
);

   import traffic_pkg::*;

   phase_e     state_q, state_d;
   lamps_t     lamps_q;
   logic       pending_q;
   logic       fromAb_q;
   logic [7:0] greenMin_q, yellow_q, allRed_q, walkTime_q;
   logic [7:0] entryDuration;
   logic       enteringWalk;
   logic       timerLoad;
   logic [7:0] timerLoadValue;
   logic [7:0] unusedTimerValue;
   logic       timerExpired;

   phase_timer u_timer (
      .clk         (clk),
      .load_i      (timerLoad),
      .loadValue_i (timerLoadValue),
      .value_o     (unusedTimerValue),
      .expired_o   (timerExpired)
   );

   // Sensors and the pending request only matter once the current phase has expired.
   always_comb begin
      state_d = state_q;
      case (state_q)
         A_GREEN:    if (timerExpired && (Sb || pending_q)) state_d = A_YELLOW;
         A_YELLOW:   if (timerExpired) state_d = ALL_RED_AB;
         ALL_RED_AB: if (timerExpired) state_d = pending_q ? PED_WALK : B_GREEN;
         B_GREEN:    if (timerExpired && (Sa || pending_q || !Sb)) state_d = B_YELLOW;
         B_YELLOW:   if (timerExpired) state_d = ALL_RED_BA;
         ALL_RED_BA: if (timerExpired) state_d = pending_q ? PED_WALK : A_GREEN;
         PED_WALK:   if (timerExpired) state_d = fromAb_q ? B_GREEN : A_GREEN;
         default:    state_d = A_GREEN;
      endcase
   end

   // Durations come from the registers as they stood before this edge, so a
   // write landing on an entry edge only affects later entries.
   always_comb begin
      entryDuration = greenMin_q;
      case (state_d)
         A_YELLOW, B_YELLOW:     entryDuration = yellow_q;
         ALL_RED_AB, ALL_RED_BA: entryDuration = allRed_q;
         PED_WALK:               entryDuration = walkTime_q;
         default:                entryDuration = greenMin_q;
      endcase
      enteringWalk   = (state_d == PED_WALK) && (state_q != PED_WALK);
      timerLoad      = reset || (state_d != state_q);
      timerLoadValue = reset ? clampDuration(8'(DEF_GREEN_MIN)) : clampDuration(entryDuration);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= A_GREEN;
         lamps_q    <= lampDecode(A_GREEN);
         pending_q  <= 1'b0;
         fromAb_q   <= 1'b0;
         greenMin_q <= 8'(DEF_GREEN_MIN);
         yellow_q   <= 8'(DEF_YELLOW);
         allRed_q   <= 8'(DEF_ALL_RED);
         walkTime_q <= 8'(DEF_WALK);
      end else begin
         state_q   <= state_d;
         lamps_q   <= lampDecode(state_d);
         pending_q <= ped_req || (pending_q && !enteringWalk);
         if (enteringWalk) begin
            fromAb_q <= (state_q == ALL_RED_AB);
         end
         if (cfg_we) begin
            case (cfg_addr)
               CFG_GREEN_MIN: greenMin_q <= cfg_data;
               CFG_YELLOW:    yellow_q   <= cfg_data;
               CFG_ALL_RED:   allRed_q   <= cfg_data;
               default:       walkTime_q <= cfg_data;
            endcase
         end
      end
   end

   assign Ra          = lamps_q.ra;
   assign Ya          = lamps_q.ya;
   assign Ga          = lamps_q.ga;
   assign Rb          = lamps_q.rb;
   assign Yb          = lamps_q.yb;
   assign Gb          = lamps_q.gb;
   assign walk        = lamps_q.walk;
   assign ped_pending = pending_q;
   assign phase       = state_q;

endmodule

// File: doc/traffic_phase_scheduler.md
TRAFFIC_PHASE_SCHEDULER -- requirements
Module: traffic_phase_scheduler

Interface
REQ-001 Parameter DEF_GREEN_MIN, default 5, reset value of the green-minimum register, in cycles.
REQ-002 Parameter DEF_YELLOW, default 2, reset value of the yellow register, in cycles.
REQ-003 Parameter DEF_ALL_RED, default 1, reset value of the all-red register, in cycles.
REQ-004 Parameter DEF_WALK, default 4, reset value of the walk register, in cycles.
REQ-005 Clocking and reset SHALL be one clock with a synchronous, active-high reset.
REQ-006 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-007 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 Port Sa / Sb, input, 1 bit each: car present on street A / street B (level).
REQ-009 Port ped_req, input, 1 bit: pedestrian button (pulse, any width).
REQ-010 Port cfg_we, input, 1 bit: configuration write strobe.
REQ-011 Port cfg_addr, input, 2 bits: 0 green_min, 1 yellow, 2 all_red, 3 walk.
REQ-012 Port cfg_data, input, 8 bits: timing value, in cycles.
REQ-013 Ports Ra/Ya/Ga and Rb/Yb/Gb, output, 1 bit each: lamp drives for street A and street B.
REQ-014 Port walk, output, 1 bit: pedestrian walk lamp.
REQ-015 Port ped_pending, output, 1 bit: a pedestrian request is latched and not yet served.
REQ-016 Port phase, output, 3 bits: current state encoding.

Function
REQ-017 Control SHALL be a Moore FSM with states A_GREEN, A_YELLOW, ALL_RED_AB, B_GREEN, B_YELLOW, ALL_RED_BA, PED_WALK.
REQ-018 Lamp outputs SHALL decode from state only, with exactly one lamp per street asserted at all times:
- A_GREEN: Ga, Rb.
- A_YELLOW: Ya, Rb.
- B_GREEN: Ra, Gb.
- B_YELLOW: Ra, Yb.
- ALL_RED_AB, ALL_RED_BA, PED_WALK: Ra, Rb.
- walk=1 only in PED_WALK.
REQ-019 Each state SHALL last exactly N cycles once its timer expires, where N is the register value loaded on state entry; a programmed value of 0 SHALL be treated as 1.
REQ-020 A_GREEN SHALL go to A_YELLOW when green_min has expired AND (Sb OR ped_pending); otherwise A_GREEN SHALL hold indefinitely (A is the rest state).
REQ-021 B_GREEN SHALL go to B_YELLOW when green_min has expired AND (Sa OR ped_pending OR NOT Sb).
REQ-022 Each yellow state SHALL advance to its all-red state when the yellow timer expires.
REQ-023 ALL_RED_AB SHALL go to PED_WALK if ped_pending, else to B_GREEN.
REQ-024 ALL_RED_BA SHALL go to PED_WALK if ped_pending, else to A_GREEN.
REQ-025 PED_WALK SHALL go to B_GREEN when entered from ALL_RED_AB, and to A_GREEN when entered from ALL_RED_BA, after the walk timer expires.
REQ-026 ped_pending SHALL set on any cycle with ped_req=1.
REQ-027 ped_pending SHALL clear on the cycle PED_WALK is entered; if ped_req=1 in that same cycle, set SHALL win and the request stays pending.
REQ-028 A cfg_we write SHALL update the addressed register on the next edge; the value SHALL be used at the next state entry only and SHALL NOT affect a running timer.
REQ-029 A write in the same cycle as a state entry SHALL NOT affect the timer loaded on that entry.
REQ-030 Sensor inputs SHALL be sampled only at timer expiry; sensor changes before expiry SHALL have no effect.

Reset
REQ-031 On reset=1 at a clock edge, the block SHALL set state=A_GREEN, Ga=1, Rb=1, all other lamps 0, walk=0, ped_pending=0.
REQ-032 On the same reset edge, the timer SHALL load DEF_GREEN_MIN and the configuration registers SHALL take their DEF_* values.
REQ-033 Reset asserted mid-operation, in any state, SHALL produce the same result within one cycle.

Structure
REQ-034 Shared package traffic_pkg SHALL hold the state encodings, the cfg_addr constants and the DEF_* default values.
REQ-035 Sub-module phase_timer SHALL implement an 8-bit loadable down-counter with load, value and expired ports.

Verification
REQ-036 Sequencing: reset, then Sb=1, Sa=0 held → A_GREEN for cycles 0-4, A_YELLOW cycles 5-6, ALL_RED_AB cycle 7, B_GREEN from cycle 8.
REQ-037 Rest state: Sa=Sb=0 for 50 cycles → Ga=1, Rb=1 throughout, phase constant.
REQ-038 Pedestrian service: 1-cycle ped_req at cycle 2 with no cars → ped_pending=1, A_YELLOW at cycle 5, walk=1 cycles 8-11, B_GREEN at cycle 12, then B_GREEN exits after 5 cycles (Sb=0), returning to A_GREEN.
REQ-039 Configuration: write cfg_addr=1, cfg_data=0 while in A_GREEN → next A_YELLOW lasts 1 cycle; write yellow=3 during A_YELLOW → current yellow unchanged, next B_YELLOW lasts 3 cycles.
REQ-040 Reset mid-phase: reset during B_YELLOW with a ped request pending → next cycle A_GREEN, ped_pending=0, config registers back to defaults.
REQ-041 Lamp invariant: random Sa/Sb/ped_req for 10k cycles → exactly one lamp per street on, and never Ga and Gb asserted together.
